pc_predict_unit: RTL and testbench
==================================

Name: pc_predict_unit

Overview:
- Registered fetch-PC generator for the pipelined Y86 core. Successor to the combinational sequential-PC update block.
- Holds the predicted PC and selects the fetch PC from the prediction, a mispredicted-jump fallthrough, or a returned address.
- Predicts jump and call targets as valC. Predicts ret targets from a parametrised return-address stack (RAS), with checkpoint/restore on branch misprediction.

Parameters:
- WIDTH, 64, address/data width of all PC-valued ports.
- RAS_DEPTH, 8, number of RAS entries (power of two, >=2).
- RESET_PC, 0, value loaded into pred_pc on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- f_stall  input  1  hold pred_pc and RAS; suppress fetch-side RAS ops.
- f_valid  input  1  fetched instruction is real (not bubble/invalid).
- f_icode  input  4  icode of instruction fetched this cycle.
- f_valC  input  WIDTH  constant/target of fetched instruction.
- f_valP  input  WIDTH  fall-through address of fetched instruction.
- m_icode  input  4  icode in memory stage.
- m_cnd  input  1  condition result of jump in memory stage.
- m_valA  input  WIDTH  fall-through PC carried with jump in memory stage.
- w_icode  input  4  icode in write-back stage.
- w_valM  input  WIDTH  return address loaded by ret in write-back.
- f_pc  output  WIDTH  PC to fetch this cycle (combinational).
- pred_pc  output  WIDTH  registered predicted PC.
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  output  1  ras_count==0.
- ras_overflow  output  1  sticky; set when a push hits a full stack.
- mispredict  output  1  m_icode==JXX (7) and !m_cnd.

Behaviour:
- Reset (async): pred_pc=RESET_PC. RAS pointer, count and checkpoint queue cleared. ras_overflow=0. Entry contents don't care. All outputs are combinationally derived from these registers.
- f_pc priority:
  - mispredict -> m_valA.
  - else w_icode==RET (9) -> w_valM.
  - else pred_pc.
  - Outputs settle within the same cycle (0 latency).
- Next pred_pc, updated on rising edge when !f_stall:
  - f_icode JXX(7) or CALL(8) -> f_valC.
  - RET(9) with RAS non-empty -> RAS top.
  - RET with RAS empty -> f_valP.
  - otherwise -> f_valP.
  - f_stall=1 holds pred_pc.
- fetch_op = f_valid && !f_stall && !mispredict.
- RAS push/pop:
  - CALL with fetch_op: push f_valP.
  - If full: overwrite oldest (circular), count stays RAS_DEPTH, set ras_overflow.
  - RET with fetch_op: pop if count>0; pop on empty is a no-op.
  - Pop only moves the pointer; entries are not erased.
- Checkpoint queue (2 entries, oldest first, holds {ptr,count}):
  - JXX with fetch_op enqueues the RAS state in effect before this cycle's op.
  - A JXX resolving (m_icode==JXX) and taken dequeues the oldest.
  - mispredict restores ptr/count from the oldest entry and clears the queue. That cycle's fetch-side op is suppressed.
  - Enqueue when full drops the oldest. Dequeue when empty is a no-op.
  - Same-cycle enqueue and dequeue: dequeue first, then enqueue.
- w_icode==RET with a mismatching prediction is corrected solely by the f_pc override; the RAS is not modified.
- Pointer arithmetic is modulo RAS_DEPTH. Count saturates at 0 and RAS_DEPTH.
- Reset asserted mid-operation clears everything immediately, regardless of clk or f_stall.

Test Plan:
- Reset: rst=1 with RESET_PC=0x100 -> pred_pc=f_pc=0x100, ras_empty=1, ras_overflow=0. Deassert, fetch NOP with f_valP=0x101 -> pred_pc=0x101 next edge.
- Call/ret: CALL f_valC=0x400, f_valP=0x20A -> pred_pc=0x400, ras_count=1. Later RET fetched -> pred_pc=0x20A, ras_count=0.
- Mispredict restore:
  - Fetch JXX f_valC=0x300 (count=1).
  - Next cycle fetch CALL f_valP=0x309 -> count=2.
  - Then m_icode=7, m_cnd=0, m_valA=0x209 -> f_pc=0x209 same cycle, count restored to 1, queue empty.
- Overflow (RAS_DEPTH=4): 5 CALLs with valP 0x10..0x50 -> count=4, ras_overflow=1. Then 4 RETs predict 0x50, 0x40, 0x30, 0x20. 5th RET with RAS empty predicts f_valP.
- Stall/priority:
  - f_stall=1 with a CALL fetched -> pred_pc and count unchanged.
  - Simultaneous mispredict and w_icode=RET -> f_pc=m_valA.
  - w_icode=RET alone with w_valM=0x777 -> f_pc=0x777.
- Async reset mid-stream: assert rst between edges with count=3 -> count=0 and pred_pc=RESET_PC immediately, before the next clk edge.

Source files
------------

// File: rtl/pc_predict_unit.sv
// Registered fetch-PC generator for the pipelined Y86 core.
// Predicts jump/call targets as valC and ret targets from a checkpointed return-address stack.
module pc_predict_unit #(
  parameter int               WIDTH     = 64,
  parameter int               RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  localparam int              PW        = $clog2(RAS_DEPTH),
  localparam int              CW        = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_stall,
  input  logic             f_valid,
  input  logic [3:0]       f_icode,
  input  logic [WIDTH-1:0] f_valC,
  input  logic [WIDTH-1:0] f_valP,
  input  logic [3:0]       m_icode,
  input  logic             m_cnd,
  input  logic [WIDTH-1:0] m_valA,
  input  logic [3:0]       w_icode,
  input  logic [WIDTH-1:0] w_valM,
  output logic [WIDTH-1:0] f_pc,
  output logic [WIDTH-1:0] pred_pc,
  output logic [CW-1:0]    ras_count,
  output logic             ras_empty,
  output logic             ras_overflow,
  output logic             mispredict
);

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;

  // Two-deep checkpoint queue, entry 0 is the oldest.
  logic [PW-1:0]    q0_ptr, q1_ptr;
  logic [CW-1:0]    q0_cnt, q1_cnt;
  logic [1:0]       q_num;

  logic [PW-1:0]    ptr_nx;
  logic [CW-1:0]    cnt_nx;
  logic             ovf_nx;
  logic [PW-1:0]    q0_ptr_nx, q1_ptr_nx;
  logic [CW-1:0]    q0_cnt_nx, q1_cnt_nx;
  logic [1:0]       q_num_nx;
  logic             push;
  logic [WIDTH-1:0] pred_nx;
  logic [WIDTH-1:0] ras_top;
  logic             fetch_op;
  logic             ras_full;

  assign mispredict = (m_icode == I_JXX) && !m_cnd;
  assign fetch_op   = f_valid && !f_stall && !mispredict;
  assign ras_full   = (count == CW'(RAS_DEPTH));
  assign ras_top    = stack[ptr - 1'b1];
  assign ras_count  = count;
  assign ras_empty  = (count == '0);

  always_comb begin
    if (mispredict)
      f_pc = m_valA;
    else if (w_icode == I_RET)
      f_pc = w_valM;
    else
      f_pc = pred_pc;
  end

  always_comb begin
    case (f_icode)
      I_JXX, I_CALL: pred_nx = f_valC;
      I_RET:         pred_nx = (count != '0) ? ras_top : f_valP;
      default:       pred_nx = f_valP;
    endcase
  end

  always_comb begin
    ptr_nx    = ptr;
    cnt_nx    = count;
    ovf_nx    = ras_overflow;
    push      = 1'b0;
    q0_ptr_nx = q0_ptr;
    q0_cnt_nx = q0_cnt;
    q1_ptr_nx = q1_ptr;
    q1_cnt_nx = q1_cnt;
    q_num_nx  = q_num;
    if (mispredict) begin
      if (q_num != 2'd0) begin
        ptr_nx = q0_ptr;
        cnt_nx = q0_cnt;
      end
      q_num_nx = 2'd0;
    end else begin
      // A resolving jump that reaches here was taken: retire its checkpoint.
      if (m_icode == I_JXX && q_num != 2'd0) begin
        q0_ptr_nx = q1_ptr;
        q0_cnt_nx = q1_cnt;
        q_num_nx  = q_num - 2'd1;
      end
      if (fetch_op) begin
        case (f_icode)
          I_CALL: begin
            push   = 1'b1;
            ptr_nx = ptr + 1'b1;
            if (ras_full)
              ovf_nx = 1'b1;
            else
              cnt_nx = count + 1'b1;
          end
          I_RET: begin
            if (count != '0) begin
              ptr_nx = ptr - 1'b1;
              cnt_nx = count - 1'b1;
            end
          end
          I_JXX: begin
            if (q_num_nx == 2'd0) begin
              q0_ptr_nx = ptr;
              q0_cnt_nx = count;
              q_num_nx  = 2'd1;
            end else if (q_num_nx == 2'd1) begin
              q1_ptr_nx = ptr;
              q1_cnt_nx = count;
              q_num_nx  = 2'd2;
            end else begin
              q0_ptr_nx = q1_ptr_nx;
              q0_cnt_nx = q1_cnt_nx;
              q1_ptr_nx = ptr;
              q1_cnt_nx = count;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_pc      <= RESET_PC;
      ptr          <= '0;
      count        <= '0;
      ras_overflow <= 1'b0;
      q0_ptr       <= '0;
      q0_cnt       <= '0;
      q1_ptr       <= '0;
      q1_cnt       <= '0;
      q_num        <= 2'd0;
    end else begin
      if (!f_stall)
        pred_pc <= pred_nx;
      ptr          <= ptr_nx;
      count        <= cnt_nx;
      ras_overflow <= ovf_nx;
      q0_ptr       <= q0_ptr_nx;
      q0_cnt       <= q0_cnt_nx;
      q1_ptr       <= q1_ptr_nx;
      q1_cnt       <= q1_cnt_nx;
      q_num        <= q_num_nx;
    end
  end

  // Entry contents need no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push)
      stack[ptr] <= f_valP;
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit with a cycle-level behavioural model
// (circular return stack plus checkpoint queue) checked every negative edge.
module tb_pc_predict_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_stall, f_valid;
  logic [3:0]  f_icode, m_icode, w_icode;
  logic [63:0] f_valC, f_valP, m_valA, w_valM;
  logic        m_cnd;
  logic [63:0] f_pc, pred_pc;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_overflow, mispredict;

  int errors = 0;
  int checks = 0;

  pc_predict_unit #(.WIDTH(64), .RAS_DEPTH(D), .RESET_PC(64'h100)) dut (
    .clk(clk), .rst(rst), .f_stall(f_stall), .f_valid(f_valid),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA),
    .w_icode(w_icode), .w_valM(w_valM),
    .f_pc(f_pc), .pred_pc(pred_pc), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_overflow(ras_overflow), .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [63:0] m_pred;
  logic [63:0] m_stk [D];
  int          m_ptr, m_cnt;
  bit          m_ovf;
  int          cq_ptr[$];
  int          cq_cnt[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pred = 64'h100;
      m_ptr  = 0;
      m_cnt  = 0;
      m_ovf  = 0;
      cq_ptr.delete();
      cq_cnt.delete();
    end else begin
      bit mis, fop;
      int pre_ptr, pre_cnt;
      mis = (m_icode == 4'd7) && !m_cnd;
      fop = f_valid && !f_stall && !mis;
      pre_ptr = m_ptr;
      pre_cnt = m_cnt;
      if (!f_stall) begin
        if (f_icode == 4'd7 || f_icode == 4'd8) m_pred = f_valC;
        else if (f_icode == 4'd9 && m_cnt > 0)  m_pred = m_stk[(m_ptr + D - 1) % D];
        else                                     m_pred = f_valP;
      end
      if (mis) begin
        if (cq_ptr.size() > 0) begin
          m_ptr = cq_ptr[0];
          m_cnt = cq_cnt[0];
        end
        cq_ptr.delete();
        cq_cnt.delete();
      end else begin
        if (m_icode == 4'd7 && cq_ptr.size() > 0) begin
          void'(cq_ptr.pop_front());
          void'(cq_cnt.pop_front());
        end
        if (fop && f_icode == 4'd8) begin
          m_stk[m_ptr] = f_valP;
          m_ptr = (m_ptr + 1) % D;
          if (m_cnt == D) m_ovf = 1;
          else m_cnt = m_cnt + 1;
        end else if (fop && f_icode == 4'd9 && m_cnt > 0) begin
          m_ptr = (m_ptr + D - 1) % D;
          m_cnt = m_cnt - 1;
        end else if (fop && f_icode == 4'd7) begin
          if (cq_ptr.size() == 2) begin
            void'(cq_ptr.pop_front());
            void'(cq_cnt.pop_front());
          end
          cq_ptr.push_back(pre_ptr);
          cq_cnt.push_back(pre_cnt);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e_fpc;
    bit e_mis;
    e_mis = (m_icode == 4'd7) && !m_cnd;
    e_fpc = e_mis ? m_valA : (w_icode == 4'd9) ? w_valM : m_pred;
    chk("model f_pc", f_pc, e_fpc);
    chk("model pred_pc", pred_pc, m_pred);
    chk("model ras_count", 64'(ras_count), 64'(m_cnt));
    chk("model ras_empty", 64'(ras_empty), 64'(m_cnt == 0));
    chk("model ras_overflow", 64'(ras_overflow), 64'(m_ovf));
    chk("model mispredict", 64'(mispredict), 64'(e_mis));
  end

  task automatic drv(input logic v, input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p);
    f_valid = v;
    f_icode = ic;
    f_valC  = c;
    f_valP  = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; f_stall = 1'b0;
    drv(1'b0, 4'd0, 64'd0, 64'd0);
    m_icode = 4'd0; m_cnd = 1'b0; m_valA = 64'd0;
    w_icode = 4'd0; w_valM = 64'd0;
    #1;
    chk("reset pred_pc", pred_pc, 64'h100);
    chk("reset f_pc", f_pc, 64'h100);
    chk("reset ras_empty", 64'(ras_empty), 64'd1);
    chk("reset ras_overflow", 64'(ras_overflow), 64'd0);
    #10 rst = 1'b0;

    drv(1, 4'd1, 0, 64'h101); tick();
    chk("nop pred_pc", pred_pc, 64'h101);
    drv(1, 4'd8, 64'h400, 64'h20A); tick();
    chk("call pred_pc", pred_pc, 64'h400);
    chk("call count", 64'(ras_count), 64'd1);
    drv(1, 4'd1, 0, 64'h401); tick();
    drv(1, 4'd9, 0, 64'h402); tick();
    chk("ret pred_pc", pred_pc, 64'h20A);
    chk("ret count", 64'(ras_count), 64'd0);

    // Mispredict restore
    drv(1, 4'd8, 64'h200, 64'h105); tick();
    drv(1, 4'd7, 64'h300, 64'h209); tick();
    chk("jxx pred_pc", pred_pc, 64'h300);
    chk("jxx count", 64'(ras_count), 64'd1);
    drv(1, 4'd8, 64'h500, 64'h309); tick();
    chk("call after jxx count", 64'(ras_count), 64'd2);
    m_icode = 4'd7; m_cnd = 1'b0; m_valA = 64'h209;
    drv(1, 4'd1, 0, 64'h20A);
    #1;
    chk("mispredict f_pc", f_pc, 64'h209);
    chk("mispredict flag", 64'(mispredict), 64'd1);
    tick();
    chk("restored count", 64'(ras_count), 64'd1);
    m_icode = 4'd0;

    // Taken jump retires its checkpoint; a later mispredict has nothing to restore
    drv(1, 4'd7, 64'h600, 64'h60A); tick();
    drv(1, 4'd8, 64'h700, 64'h60B); tick();
    m_icode = 4'd7; m_cnd = 1'b1;
    drv(1, 4'd1, 0, 64'h701); tick();
    chk("taken dequeue count", 64'(ras_count), 64'd2);
    m_cnd = 1'b0; m_valA = 64'h60A;
    drv(1, 4'd1, 0, 64'h60B); tick();
    chk("empty queue no restore", 64'(ras_count), 64'd2);
    m_icode = 4'd0;

    // Overflow
    for (int i = 1; i <= 5; i++) begin
      drv(1, 4'd8, 64'h800, 64'(i * 16)); tick();
    end
    chk("overflow count", 64'(ras_count), 64'd4);
    chk("overflow flag", 64'(ras_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drv(1, 4'd9, 0, 64'h900 + 64'(i)); tick();
      chk("ras pop order", pred_pc, 64'h50 - 64'(i * 16));
    end
    drv(1, 4'd9, 0, 64'h999); tick();
    chk("ret on empty", pred_pc, 64'h999);
    chk("ret on empty count", 64'(ras_count), 64'd0);

    // Stall
    drv(1, 4'd1, 0, 64'hA00); tick();
    f_stall = 1'b1;
    drv(1, 4'd8, 64'hB00, 64'hA0A); tick();
    chk("stall pred_pc", pred_pc, 64'hA00);
    chk("stall count", 64'(ras_count), 64'd0);
    f_stall = 1'b0;

    // f_pc priority
    m_icode = 4'd7; m_cnd = 1'b0; m_valA = 64'hC00;
    w_icode = 4'd9; w_valM = 64'h777;
    drv(1, 4'd1, 0, 64'hC01);
    #1;
    chk("priority mispredict", f_pc, 64'hC00);
    m_icode = 4'd0;
    #1;
    chk("priority ret", f_pc, 64'h777);
    tick();
    w_icode = 4'd0;

    // Async reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drv(1, 4'd8, 64'hE00, 64'hD0 + 64'(i)); tick();
    end
    chk("pre-reset count", 64'(ras_count), 64'd3);
    drv(1, 4'd1, 0, 64'hD3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async rst count", 64'(ras_count), 64'd0);
    chk("async rst pred_pc", pred_pc, 64'h100);
    chk("async rst overflow", 64'(ras_overflow), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
    chk("post reset pred_pc", pred_pc, 64'hD3);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
